// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with blanked, registered colour output
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_pix_en,
    input  logic [7:0]  in_pix_r,
    input  logic [7:0]  in_pix_g,
    input  logic [7:0]  in_pix_b,
    output logic [10:0] out_pix_x,
    output logic [10:0] out_pix_y,
    output logic        out_pix_active,
    output logic        out_pix_vblank,
    output logic        out_vga_hs,
    output logic        out_vga_vs,
    output logic        out_frame_start,
    output logic [7:0]  out_vga_r,
    output logic [7:0]  out_vga_g,
    output logic [7:0]  out_vga_b,
    output logic        out_vga_hs_q,
    output logic        out_vga_vs_q
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_h;
    logic [10:0] r_v;
    logic [7:0]  r_r;
    logic [7:0]  r_g;
    logic [7:0]  r_b;
    logic        r_hs_q;
    logic        r_vs_q;
    logic        w_active;
    logic        w_hs_on;
    logic        w_vs_on;
    logic        w_hs;
    logic        w_vs;

    // Line and frame wrap happen on the same enabled edge at the last pixel of the frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (in_pix_en) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? 11'd0 : r_v + 11'd1;
            end else begin
                r_h <= r_h + 11'd1;
            end
        end
    end

    assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs_on  = (r_h >= HS_BEG) && (r_h < HS_END);
    assign w_vs_on  = (r_v >= VS_BEG) && (r_v < VS_END);
    assign w_hs     = w_hs_on ? HS_POL : ~HS_POL;
    assign w_vs     = w_vs_on ? VS_POL : ~VS_POL;

    // Colour is gated by the active decode before the register, so blanking-interval input never reaches the pins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
            r_hs_q <= ~HS_POL;
            r_vs_q <= ~VS_POL;
        end else if (in_pix_en) begin
            r_r    <= w_active ? in_pix_r : 8'd0;
            r_g    <= w_active ? in_pix_g : 8'd0;
            r_b    <= w_active ? in_pix_b : 8'd0;
            r_hs_q <= w_hs;
            r_vs_q <= w_vs;
        end
    end

    assign out_pix_x       = r_h;
    assign out_pix_y       = r_v;
    assign out_pix_active  = w_active;
    assign out_pix_vblank  = (r_v >= V_ACT);
    assign out_vga_hs      = w_hs;
    assign out_vga_vs      = w_vs;
    assign out_frame_start = in_pix_en && (r_h == 11'd0) && (r_v == 11'd0);
    assign out_vga_r       = r_r;
    assign out_vga_g       = r_g;
    assign out_vga_b       = r_b;
    assign out_vga_hs_q    = r_hs_q;
    assign out_vga_vs_q    = r_vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (full-size and reduced raster)
module tb_vga_timing_gen;

    localparam int B_HA = 640, B_HF = 16, B_HSW = 96, B_HB = 48;
    localparam int B_VA = 480, B_VF = 10, B_VSW = 2,  B_VB = 33;
    localparam int B_HT = B_HA + B_HF + B_HSW + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VSW + B_VB;
    localparam logic B_HP = 1'b0, B_VP = 1'b0;

    localparam int S_HA = 20, S_HF = 4, S_HSW = 6, S_HB = 5;
    localparam int S_VA = 12, S_VF = 2, S_VSW = 2, S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HSW + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VSW + S_VB;
    localparam logic S_HP = 1'b1, S_VP = 1'b0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        b_rst, b_en, s_rst, s_en;
    logic [7:0]  b_r, b_g, b_b, s_r, s_g, s_b;
    logic [10:0] b_x, b_y, s_x, s_y;
    logic        b_act, b_vbl, b_hs, b_vs, b_fs, b_hsq, b_vsq;
    logic        s_act, s_vbl, s_hs, s_vs, s_fs, s_hsq, s_vsq;
    logic [7:0]  b_vr, b_vg, b_vb, s_vr, s_vg, s_vb;

    vga_timing_gen u_big (
        .clock(clock), .reset(b_rst), .in_pix_en(b_en),
        .in_pix_r(b_r), .in_pix_g(b_g), .in_pix_b(b_b),
        .out_pix_x(b_x), .out_pix_y(b_y), .out_pix_active(b_act), .out_pix_vblank(b_vbl),
        .out_vga_hs(b_hs), .out_vga_vs(b_vs), .out_frame_start(b_fs),
        .out_vga_r(b_vr), .out_vga_g(b_vg), .out_vga_b(b_vb),
        .out_vga_hs_q(b_hsq), .out_vga_vs_q(b_vsq)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HSW), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VSW), .V_BP(S_VB),
        .HS_POL(S_HP), .VS_POL(S_VP)
    ) u_small (
        .clock(clock), .reset(s_rst), .in_pix_en(s_en),
        .in_pix_r(s_r), .in_pix_g(s_g), .in_pix_b(s_b),
        .out_pix_x(s_x), .out_pix_y(s_y), .out_pix_active(s_act), .out_pix_vblank(s_vbl),
        .out_vga_hs(s_hs), .out_vga_vs(s_vs), .out_frame_start(s_fs),
        .out_vga_r(s_vr), .out_vga_g(s_vg), .out_vga_b(s_vb),
        .out_vga_hs_q(s_hsq), .out_vga_vs_q(s_vsq)
    );

    int n_checks, n_pass;

    // Reference: raster position is the count of enabled cycles since reset, modulo the frame size.
    int          bn, sn;
    logic [7:0]  bm_r, bm_g, bm_b, sm_r, sm_g, sm_b;
    logic        bm_hsq, bm_vsq, sm_hsq, sm_vsq;

    function automatic int f_x(int n, bit sm);
        return n % (sm ? S_HT : B_HT);
    endfunction

    function automatic int f_y(int n, bit sm);
        return (n / (sm ? S_HT : B_HT)) % (sm ? S_VT : B_VT);
    endfunction

    function automatic logic f_act(int n, bit sm);
        return (f_x(n, sm) < (sm ? S_HA : B_HA)) && (f_y(n, sm) < (sm ? S_VA : B_VA));
    endfunction

    function automatic logic f_vbl(int n, bit sm);
        return f_y(n, sm) >= (sm ? S_VA : B_VA);
    endfunction

    function automatic logic f_hs(int n, bit sm);
        int   st  = sm ? (S_HA + S_HF) : (B_HA + B_HF);
        int   w   = sm ? S_HSW : B_HSW;
        logic pol = sm ? S_HP : B_HP;
        int   x   = f_x(n, sm);
        return (x >= st && x < st + w) ? pol : ~pol;
    endfunction

    function automatic logic f_vs(int n, bit sm);
        int   st  = sm ? (S_VA + S_VF) : (B_VA + B_VF);
        int   w   = sm ? S_VSW : B_VSW;
        logic pol = sm ? S_VP : B_VP;
        int   y   = f_y(n, sm);
        return (y >= st && y < st + w) ? pol : ~pol;
    endfunction

    task automatic b_mreset();
        bn = 0; bm_r = 8'd0; bm_g = 8'd0; bm_b = 8'd0; bm_hsq = ~B_HP; bm_vsq = ~B_VP;
    endtask

    task automatic s_mreset();
        sn = 0; sm_r = 8'd0; sm_g = 8'd0; sm_b = 8'd0; sm_hsq = ~S_HP; sm_vsq = ~S_VP;
    endtask

    task automatic b_step();
        @(posedge clock);
        if (b_rst) b_mreset();
        else if (b_en) begin
            bm_r = f_act(bn, 0) ? b_r : 8'd0;
            bm_g = f_act(bn, 0) ? b_g : 8'd0;
            bm_b = f_act(bn, 0) ? b_b : 8'd0;
            bm_hsq = f_hs(bn, 0);
            bm_vsq = f_vs(bn, 0);
            bn = (bn + 1) % (B_HT * B_VT);
        end
        #1;
    endtask

    task automatic s_step();
        @(posedge clock);
        if (s_rst) s_mreset();
        else if (s_en) begin
            sm_r = f_act(sn, 1) ? s_r : 8'd0;
            sm_g = f_act(sn, 1) ? s_g : 8'd0;
            sm_b = f_act(sn, 1) ? s_b : 8'd0;
            sm_hsq = f_hs(sn, 1);
            sm_vsq = f_vs(sn, 1);
            sn = (sn + 1) % (S_HT * S_VT);
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++; if (b_x !== 11'd0 || b_y !== 11'd0) $display("FAIL reset_xy got %0d,%0d exp 0,0", b_x, b_y); else n_pass++;
        n_checks++; if ({b_act, b_vbl} !== 2'b10) $display("FAIL reset_act_vbl got %b exp 10", {b_act, b_vbl}); else n_pass++;
        n_checks++; if ({b_hs, b_vs, b_hsq, b_vsq} !== 4'b1111) $display("FAIL reset_sync got %b exp 1111", {b_hs, b_vs, b_hsq, b_vsq}); else n_pass++;
        n_checks++; if (b_fs !== 1'b0) $display("FAIL reset_fs_en0 got %b exp 0", b_fs); else n_pass++;
        n_checks++; if ({b_vr, b_vg, b_vb} !== 24'd0) $display("FAIL reset_rgb got %h exp 0", {b_vr, b_vg, b_vb}); else n_pass++;
        b_en = 1'b1; #1;
        n_checks++; if (b_fs !== 1'b1) $display("FAIL reset_fs_en1 got %b exp 1", b_fs); else n_pass++;
        b_rst = 1'b0; b_mreset();
        b_r = 8'h55; b_g = 8'h66; b_b = 8'h77;
        b_step();
        @(negedge clock);
        n_checks++; if (b_x !== 11'd1 || b_y !== 11'd0) $display("FAIL release_first got %0d,%0d exp 1,0", b_x, b_y); else n_pass++;
        n_checks++; if ({b_vr, b_vg, b_vb} !== 24'h556677) $display("FAIL release_rgb got %h exp 556677", {b_vr, b_vg, b_vb}); else n_pass++;
        b_step();
        for (int i = 0; i < 4000 && bn != 2 * B_HT + 300; i++) begin
            b_r = 8'($urandom); b_g = 8'($urandom); b_b = 8'($urandom);
            b_step();
        end
        @(negedge clock);
        n_checks++; if (b_x !== 11'd300 || b_y !== 11'd2) $display("FAIL midline_pos got %0d,%0d exp 300,2", b_x, b_y); else n_pass++;
        n_checks++; if ({b_vr, b_vg, b_vb} !== {bm_r, bm_g, bm_b}) $display("FAIL midline_rgb got %h exp %h", {b_vr, b_vg, b_vb}, {bm_r, bm_g, bm_b}); else n_pass++;
        #2; b_rst = 1'b1; b_mreset(); #1;
        n_checks++; if (b_x !== 11'd0 || b_y !== 11'd0) $display("FAIL async_xy got %0d,%0d exp 0,0", b_x, b_y); else n_pass++;
        n_checks++; if ({b_vr, b_vg, b_vb} !== 24'd0) $display("FAIL async_rgb got %h exp 0", {b_vr, b_vg, b_vb}); else n_pass++;
        n_checks++; if ({b_hsq, b_vsq, b_act, b_fs} !== 4'b1111) $display("FAIL async_flags got %b exp 1111", {b_hsq, b_vsq, b_act, b_fs}); else n_pass++;
        b_step();
        @(negedge clock);
        n_checks++; if (b_x !== 11'd0) $display("FAIL reset_hold_x got %0d exp 0", b_x); else n_pass++;
        b_rst = 1'b0;
        b_step();
        @(negedge clock);
        n_checks++; if (b_x !== 11'd1 || b_y !== 11'd0) $display("FAIL rerelease got %0d,%0d exp 1,0", b_x, b_y); else n_pass++;
        b_step();
    endtask

    task automatic test_active_edge();
        int mx;
        b_rst = 1'b1; b_mreset(); #1; b_rst = 1'b0; b_en = 1'b1;
        for (int i = 0; i < 646; i++) begin
            b_r = 8'hAA; b_g = 8'($urandom); b_b = 8'($urandom);
            @(negedge clock);
            mx = f_x(bn, 0);
            if (mx == 639) begin
                n_checks++; if (b_act !== 1'b1 || b_x !== 11'd639) $display("FAIL act_639 got %b x=%0d exp 1", b_act, b_x); else n_pass++;
            end
            if (mx == 640) begin
                n_checks++; if (b_act !== 1'b0 || b_x !== 11'd640) $display("FAIL act_640 got %b x=%0d exp 0", b_act, b_x); else n_pass++;
                n_checks++; if (b_vr !== 8'hAA) $display("FAIL r_at_640 got %h exp aa", b_vr); else n_pass++;
            end
            if (mx == 641) begin
                n_checks++; if (b_vr !== 8'h00) $display("FAIL r_at_641 got %h exp 00", b_vr); else n_pass++;
            end
            if (mx >= 630 && mx <= 645) begin
                n_checks++; if ({b_vr, b_vg, b_vb} !== {bm_r, bm_g, bm_b}) $display("FAIL edge_rgb x=%0d got %h exp %h", mx, {b_vr, b_vg, b_vb}, {bm_r, bm_g, bm_b}); else n_pass++;
            end
            b_step();
        end
    endtask

    task automatic test_line_wrap();
        int target, mx, lo_cnt, lo_first, lo_last, q_cnt, q_first, q_last;
        bit done;
        target = 10 * B_HT + B_HT - 1;
        lo_cnt = 0; lo_first = -1; lo_last = -1; q_cnt = 0; q_first = -1; q_last = -1; done = 0;
        for (int i = 0; i < 12000 && !done; i++) begin
            b_r = 8'($urandom); b_g = 8'($urandom); b_b = 8'($urandom);
            @(negedge clock);
            if (f_y(bn, 0) == 10) begin
                mx = f_x(bn, 0);
                if (b_hs === 1'b0) begin lo_cnt++; if (lo_first < 0) lo_first = mx; lo_last = mx; end
                if (b_hsq === 1'b0) begin q_cnt++; if (q_first < 0) q_first = mx; q_last = mx; end
                n_checks++; if (b_hs !== f_hs(bn, 0) || b_hsq !== bm_hsq) $display("FAIL line10_hs x=%0d got %b%b exp %b%b", mx, b_hs, b_hsq, f_hs(bn, 0), bm_hsq); else n_pass++;
            end
            if (bn == target) begin
                done = 1;
                n_checks++; if (b_x !== 11'd799 || b_y !== 11'd10) $display("FAIL pre_wrap got %0d,%0d exp 799,10", b_x, b_y); else n_pass++;
            end
            b_step();
        end
        @(negedge clock);
        n_checks++; if (!done || b_x !== 11'd0 || b_y !== 11'd11) $display("FAIL line_wrap got %0d,%0d exp 0,11 reached=%0d", b_x, b_y, done); else n_pass++;
        n_checks++; if (lo_cnt != 96 || lo_first != 656 || lo_last != 751) $display("FAIL hs_window got %0d [%0d,%0d] exp 96 [656,751]", lo_cnt, lo_first, lo_last); else n_pass++;
        n_checks++; if (q_cnt != 96 || q_first != 657 || q_last != 752) $display("FAIL hsq_window got %0d [%0d,%0d] exp 96 [657,752]", q_cnt, q_first, q_last); else n_pass++;
        b_en = 1'b0;
        b_step();
    endtask

    task automatic test_full_frame();
        int fs_cnt, fs_first, fs_second, vs_cyc, vbl_cyc;
        fs_cnt = 0; fs_first = -1; fs_second = -1; vs_cyc = 0; vbl_cyc = 0;
        s_rst = 1'b1; s_mreset(); #1; s_rst = 1'b0; s_en = 1'b1;
        for (int c = 0; c < 2 * S_HT * S_VT; c++) begin
            s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
            @(negedge clock);
            n_checks++; if (s_x !== 11'(f_x(sn, 1)) || s_y !== 11'(f_y(sn, 1))) $display("FAIL ff_xy got %0d,%0d exp %0d,%0d", s_x, s_y, f_x(sn, 1), f_y(sn, 1)); else n_pass++;
            n_checks++; if ({s_vbl, s_vs, s_fs} !== {f_vbl(sn, 1), f_vs(sn, 1), sn == 0}) $display("FAIL ff_flags n=%0d got %b exp %b", sn, {s_vbl, s_vs, s_fs}, {f_vbl(sn, 1), f_vs(sn, 1), sn == 0}); else n_pass++;
            if (sn == S_HT * S_VT - 1) begin
                n_checks++; if (s_x !== 11'(S_HT - 1) || s_y !== 11'(S_VT - 1)) $display("FAIL ff_last got %0d,%0d exp %0d,%0d", s_x, s_y, S_HT - 1, S_VT - 1); else n_pass++;
            end
            if (s_fs === 1'b1) begin fs_cnt++; if (fs_first < 0) fs_first = c; else fs_second = c; end
            if (c < S_HT * S_VT) begin
                if (s_vs === S_VP) vs_cyc++;
                if (s_vbl === 1'b1) vbl_cyc++;
            end
            s_step();
        end
        n_checks++; if (fs_cnt != 2 || fs_second - fs_first != S_HT * S_VT) $display("FAIL ff_frame_start got %0d pulses period %0d exp 2 period %0d", fs_cnt, fs_second - fs_first, S_HT * S_VT); else n_pass++;
        n_checks++; if (vs_cyc != S_VSW * S_HT) $display("FAIL ff_vs_cycles got %0d exp %0d", vs_cyc, S_VSW * S_HT); else n_pass++;
        n_checks++; if (vbl_cyc != (S_VT - S_VA) * S_HT) $display("FAIL ff_vblank_cycles got %0d exp %0d", vbl_cyc, (S_VT - S_VA) * S_HT); else n_pass++;
    endtask

    task automatic test_en_toggle();
        int fs_cnt, fs_first, fs_second;
        fs_cnt = 0; fs_first = -1; fs_second = -1;
        s_rst = 1'b1; s_mreset(); #1; s_rst = 1'b0;
        for (int c = 0; c < 4 * S_HT * S_VT; c++) begin
            s_en = (c % 2 == 0);
            s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
            @(negedge clock);
            n_checks++; if (s_x !== 11'(f_x(sn, 1)) || s_y !== 11'(f_y(sn, 1))) $display("FAIL tog_xy c=%0d got %0d,%0d exp %0d,%0d", c, s_x, s_y, f_x(sn, 1), f_y(sn, 1)); else n_pass++;
            n_checks++; if ({s_vr, s_vg, s_vb, s_hsq, s_vsq} !== {sm_r, sm_g, sm_b, sm_hsq, sm_vsq}) $display("FAIL tog_out c=%0d got %h exp %h", c, {s_vr, s_vg, s_vb, s_hsq, s_vsq}, {sm_r, sm_g, sm_b, sm_hsq, sm_vsq}); else n_pass++;
            if (s_fs === 1'b1) begin fs_cnt++; if (fs_first < 0) fs_first = c; else fs_second = c; end
            s_step();
        end
        n_checks++; if (fs_cnt != 2 || fs_second - fs_first != 2 * S_HT * S_VT) $display("FAIL tog_period got %0d pulses period %0d exp 2 period %0d", fs_cnt, fs_second - fs_first, 2 * S_HT * S_VT); else n_pass++;
    endtask

    task automatic test_vblank_rgb();
        bit wrapped;
        wrapped = 0;
        s_rst = 1'b1; s_mreset(); #1; s_rst = 1'b0; s_en = 1'b1;
        for (int i = 0; i < 2000 && sn != S_VA * S_HT; i++) begin
            s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
            s_step();
        end
        for (int i = 0; i < 2000 && !wrapped; i++) begin
            s_en = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            s_r = 8'hFF; s_g = 8'hFF; s_b = 8'hFF;
            s_step();
            @(negedge clock);
            n_checks++; if ({s_vr, s_vg, s_vb} !== 24'd0) $display("FAIL vblank_rgb y=%0d got %h exp 0", s_y, {s_vr, s_vg, s_vb}); else n_pass++;
            if (sn == 0) wrapped = 1;
        end
        n_checks++; if (!wrapped) $display("FAIL vblank_wrap_timeout got n=%0d exp 0", sn); else n_pass++;
        s_en = 1'b0;
        s_step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            s_en = ($urandom_range(0, 3) != 0);
            s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin s_rst = 1'b1; s_mreset(); end
            else s_rst = 1'b0;
            @(negedge clock);
            n_checks++; if (s_x !== 11'(f_x(sn, 1)) || s_y !== 11'(f_y(sn, 1))) $display("FAIL rnd_xy got %0d,%0d exp %0d,%0d", s_x, s_y, f_x(sn, 1), f_y(sn, 1)); else n_pass++;
            n_checks++; if ({s_act, s_vbl, s_hs, s_vs} !== {f_act(sn, 1), f_vbl(sn, 1), f_hs(sn, 1), f_vs(sn, 1)}) $display("FAIL rnd_decode n=%0d got %b exp %b", sn, {s_act, s_vbl, s_hs, s_vs}, {f_act(sn, 1), f_vbl(sn, 1), f_hs(sn, 1), f_vs(sn, 1)}); else n_pass++;
            n_checks++; if (s_fs !== (s_en && sn == 0)) $display("FAIL rnd_fs n=%0d got %b exp %b", sn, s_fs, s_en && sn == 0); else n_pass++;
            n_checks++; if ({s_vr, s_vg, s_vb, s_hsq, s_vsq} !== {sm_r, sm_g, sm_b, sm_hsq, sm_vsq}) $display("FAIL rnd_out n=%0d got %h exp %h", sn, {s_vr, s_vg, s_vb, s_hsq, s_vsq}, {sm_r, sm_g, sm_b, sm_hsq, sm_vsq}); else n_pass++;
            s_step();
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        b_rst = 1'b1; b_en = 1'b0; b_r = 8'd0; b_g = 8'd0; b_b = 8'd0;
        s_rst = 1'b1; s_en = 1'b0; s_r = 8'd0; s_g = 8'd0; s_b = 8'd0;
        b_mreset(); s_mreset();
        test_reset();
        test_active_edge();
        test_line_wrap();
        test_full_frame();
        test_en_toggle();
        test_vblank_rgb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
